// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA raster timing generator.
//
// Produces active-area coordinates, pixel-valid, polarity-adjusted sync
// outputs, line/frame start markers and a wrapping frame counter. Timing is
// reprogrammable through a one-deep valid/ready config slot; a pending config
// only becomes live on the frame-wrap cycle, so a frame is never split
// between two timing sets.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   cfg_{h,v}_{act,fp,sw,bp}, cfg_{hs,vs}_pol, cfg_valid   config offer
//   cfg_ready           config slot empty
//   cfg_err             one-cycle pulse: offered config rejected
//   pix_x, pix_y, pix_v active-area coordinate / valid
//   hs, vs              sync outputs, polarity applied
//   line_start, frame_start   one-cycle markers
//   frame_id            frame counter, wraps at FRAMES
module vga_timing_gen #(
   parameter int pA     = 10,
   parameter int fA     = 32,
   parameter int FRAMES = 275625,
   parameter int H_ACT  = 640,
   parameter int H_FP   = 16,
   parameter int H_SW   = 96,
   parameter int H_BP   = 48,
   parameter int V_ACT  = 480,
   parameter int V_FP   = 10,
   parameter int V_SW   = 2,
   parameter int V_BP   = 33,
   parameter bit HS_POL = 1'b0,
   parameter bit VS_POL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [pA-1:0] cfg_h_act,
   input  logic [pA-1:0] cfg_h_fp,
   input  logic [pA-1:0] cfg_h_sw,
   input  logic [pA-1:0] cfg_h_bp,
   input  logic [pA-1:0] cfg_v_act,
   input  logic [pA-1:0] cfg_v_fp,
   input  logic [pA-1:0] cfg_v_sw,
   input  logic [pA-1:0] cfg_v_bp,
   input  logic          cfg_hs_pol,
   input  logic          cfg_vs_pol,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   output logic          cfg_err,
   output logic [pA-1:0] pix_x,
   output logic [pA-1:0] pix_y,
   output logic          pix_v,
   output logic          hs,
   output logic          vs,
   output logic          line_start,
   output logic          frame_start,
   output logic [fA-1:0] frame_id
);

   typedef struct packed {
      logic [pA-1:0] act;
      logic [pA-1:0] fp;
      logic [pA-1:0] sw;
      logic [pA-1:0] bp;
   } axis_t;

   typedef struct packed {
      axis_t h;
      axis_t v;
      logic  hs_pol;
      logic  vs_pol;
   } tset_t;

   localparam logic [pA+1:0] ONE     = (pA+2)'(1);
   localparam logic [pA+1:0] CNT_MAX = (pA+2)'((64'd1 << pA) - 64'd1);
   localparam logic [fA-1:0] FID_MAX = fA'(FRAMES - 1);
   localparam tset_t RST_SET = '{
      h: '{pA'(H_ACT), pA'(H_FP), pA'(H_SW), pA'(H_BP)},
      v: '{pA'(V_ACT), pA'(V_FP), pA'(V_SW), pA'(V_BP)},
      hs_pol: HS_POL, vs_pol: VS_POL};

   // Sums are widened by two bits so four pA-bit fields cannot overflow.
   function automatic logic [pA+1:0] ext(input logic [pA-1:0] a);
      return {2'b00, a};
   endfunction

   function automatic logic [pA+1:0] total(input axis_t a);
      return ext(a.act) + ext(a.fp) + ext(a.sw) + ext(a.bp);
   endfunction

   function automatic logic axis_ok(input axis_t a);
      return (a.act != '0) && (a.sw != '0) && (total(a) <= CNT_MAX);
   endfunction

   function automatic logic in_sync(input logic [pA-1:0] c, input axis_t a);
      return (ext(c) >= ext(a.act) + ext(a.fp)) &&
             (ext(c) <  ext(a.act) + ext(a.fp) + ext(a.sw));
   endfunction

   tset_t         live_q, pend_q, cfg_in;
   logic          pend_vld_q, run_q, err_q;
   logic [pA-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [fA-1:0] fid_q, fid_d;
   logic          h_wrap, v_wrap, f_wrap, cfg_acc, cfg_ok;
   logic          pix_v_q, pix_v_d, hs_q, hs_d, vs_q, vs_d;
   logic          ls_q, ls_d, fs_q, fs_d;
   logic [pA-1:0] px_q, px_d, py_q, py_d;

   always_comb begin
      cfg_in  = '{h: '{cfg_h_act, cfg_h_fp, cfg_h_sw, cfg_h_bp},
                  v: '{cfg_v_act, cfg_v_fp, cfg_v_sw, cfg_v_bp},
                  hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};
      cfg_acc = cfg_valid && !pend_vld_q;
      cfg_ok  = axis_ok(cfg_in.h) && axis_ok(cfg_in.v);

      h_wrap  = (ext(h_cnt_q) + ONE) == total(live_q.h);
      v_wrap  = (ext(v_cnt_q) + ONE) == total(live_q.v);
      f_wrap  = h_wrap && v_wrap;

      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      fid_d   = fid_q;
      if (f_wrap) fid_d = (fid_q == FID_MAX) ? '0 : fid_q + 1'b1;

      // Output stage decodes the current counter state; registered below.
      pix_v_d = (h_cnt_q < live_q.h.act) && (v_cnt_q < live_q.v.act);
      px_d    = pix_v_d ? h_cnt_q : '0;
      py_d    = pix_v_d ? v_cnt_q : '0;
      hs_d    = in_sync(h_cnt_q, live_q.h) ~^ live_q.hs_pol;
      vs_d    = in_sync(v_cnt_q, live_q.v) ~^ live_q.vs_pol;
      ls_d    = (h_cnt_q == '0);
      fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q      <= 1'b0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         fid_q      <= '0;
         live_q     <= RST_SET;
         pend_q     <= RST_SET;
         pend_vld_q <= 1'b0;
         err_q      <= 1'b0;
         pix_v_q    <= 1'b0;
         px_q       <= '0;
         py_q       <= '0;
         hs_q       <= ~HS_POL;
         vs_q       <= ~VS_POL;
         ls_q       <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         // First edge after release only arms the counters, so the 0,0
         // pixel appears on the outputs after the second edge.
         run_q <= 1'b1;
         if (run_q) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            fid_q   <= fid_d;
            pix_v_q <= pix_v_d;
            px_q    <= px_d;
            py_q    <= py_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            if (f_wrap && pend_vld_q) begin
               live_q     <= pend_q;
               pend_vld_q <= 1'b0;
            end
         end
         // Acceptance needs an empty slot, so it never collides with apply.
         err_q <= cfg_acc && !cfg_ok;
         if (cfg_acc && cfg_ok) begin
            pend_q     <= cfg_in;
            pend_vld_q <= 1'b1;
         end
      end
   end

   assign cfg_ready   = !pend_vld_q;
   assign cfg_err     = err_q;
   assign pix_v       = pix_v_q;
   assign pix_x       = px_q;
   assign pix_y       = py_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign frame_id    = fid_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen with a reduced raster
// (23 x 10 clocks, FRAMES=3) so several frames fit in a short run. A small
// behavioural model of the raster tracks every cycle; hand-computed totals are
// checked at the end of each directed phase.
module tb_vga_timing_gen;
   localparam int PA = 10;
   localparam int FA = 8;
   localparam int FR = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PA-1:0] cfg_h_act, cfg_h_fp, cfg_h_sw, cfg_h_bp;
   logic [PA-1:0] cfg_v_act, cfg_v_fp, cfg_v_sw, cfg_v_bp;
   logic          cfg_hs_pol, cfg_vs_pol, cfg_valid;
   logic          cfg_ready, cfg_err, pix_v, hs, vs, line_start, frame_start;
   logic [PA-1:0] pix_x, pix_y;
   logic [FA-1:0] frame_id;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .pA(PA), .fA(FA), .FRAMES(FR),
      .H_ACT(16), .H_FP(2), .H_SW(3), .H_BP(2),
      .V_ACT(6),  .V_FP(1), .V_SW(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sw(cfg_h_sw), .cfg_h_bp(cfg_h_bp),
      .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sw(cfg_v_sw), .cfg_v_bp(cfg_v_bp),
      .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err),
      .pix_x(pix_x), .pix_y(pix_y), .pix_v(pix_v), .hs(hs), .vs(vs),
      .line_start(line_start), .frame_start(frame_start), .frame_id(frame_id)
   );

   int nchk = 0;
   int nfail = 0;

   // Timing sets: [0..3] h act/fp/sw/bp, [4..7] v act/fp/sw/bp, [8] hpol, [9] vpol
   int dflt[10] = '{16, 2, 3, 2, 6, 1, 2, 1, 0, 0};
   int mt[10];
   int pt[10];
   int oc[10];
   int m_pend, m_run, mh, mv, mfid, e_h;
   int e_pv, e_px, e_py, e_hs, e_vs, e_ls, e_fs, e_err;
   int st_pv, st_hs0, st_hs1, st_vs0, st_vs1, st_fh0, st_fh1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pix_v", pix_v, e_pv);
      chk("pix_x", pix_x, e_px);
      chk("pix_y", pix_y, e_py);
      chk("hs", hs, e_hs);
      chk("vs", vs, e_vs);
      chk("line_start", line_start, e_ls);
      chk("frame_start", frame_start, e_fs);
      chk("frame_id", frame_id, mfid);
      chk("cfg_ready", cfg_ready, (m_pend == 0));
      chk("cfg_err", cfg_err, e_err);
   endtask

   task automatic clear_stats();
      st_pv = 0; st_hs0 = 0; st_hs1 = 0; st_vs0 = 0; st_vs1 = 0;
      st_fh0 = -1; st_fh1 = -1;
   endtask

   task automatic set_cfg(input int ha, input int hf, input int hsw, input int hb,
                          input int va, input int vf, input int vsw, input int vb,
                          input int hp, input int vp);
      oc = '{ha, hf, hsw, hb, va, vf, vsw, vb, hp, vp};
      cfg_h_act = PA'(ha); cfg_h_fp = PA'(hf); cfg_h_sw = PA'(hsw); cfg_h_bp = PA'(hb);
      cfg_v_act = PA'(va); cfg_v_fp = PA'(vf); cfg_v_sw = PA'(vsw); cfg_v_bp = PA'(vb);
      cfg_hs_pol = (hp != 0);
      cfg_vs_pol = (vp != 0);
   endtask

   // Model state and expectations while reset is asserted.
   task automatic model_reset();
      mt = dflt; m_pend = 0; m_run = 0; mh = 0; mv = 0; mfid = 0;
      e_pv = 0; e_px = 0; e_py = 0; e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0; e_err = 0;
   endtask

   // One clock: advance the model at the edge, then compare after it settles.
   task automatic tick();
      int  htot, vtot;
      bit  acc, ok, hsa, vsa;
      @(posedge clk);
      htot = mt[0] + mt[1] + mt[2] + mt[3];
      vtot = mt[4] + mt[5] + mt[6] + mt[7];
      acc  = (cfg_valid === 1'b1) && (m_pend == 0);
      ok   = (oc[0] != 0) && (oc[2] != 0) && (oc[4] != 0) && (oc[6] != 0) &&
             (oc[0] + oc[1] + oc[2] + oc[3] <= 1023) &&
             (oc[4] + oc[5] + oc[6] + oc[7] <= 1023);
      e_err = (acc && !ok) ? 1 : 0;
      if (m_run != 0) begin
         e_h  = mh;
         e_pv = (mh < mt[0] && mv < mt[4]) ? 1 : 0;
         e_px = (e_pv != 0) ? mh : 0;
         e_py = (e_pv != 0) ? mv : 0;
         hsa  = (mh >= mt[0] + mt[1]) && (mh < mt[0] + mt[1] + mt[2]);
         vsa  = (mv >= mt[4] + mt[5]) && (mv < mt[4] + mt[5] + mt[6]);
         e_hs = hsa ? mt[8] : 1 - mt[8];
         e_vs = vsa ? mt[9] : 1 - mt[9];
         e_ls = (mh == 0) ? 1 : 0;
         e_fs = (mh == 0 && mv == 0) ? 1 : 0;
         if (mh == htot - 1) begin
            mh = 0;
            if (mv == vtot - 1) begin
               mv = 0;
               mfid = (mfid == FR - 1) ? 0 : mfid + 1;
               if (m_pend != 0) begin
                  mt = pt;
                  m_pend = 0;
               end
            end else mv++;
         end else mh++;
      end
      m_run = 1;
      if (acc && ok) begin
         pt = oc;
         m_pend = 1;
      end
      #1;
      check_all();
      st_pv += int'(pix_v);
      if (hs === 1'b0) begin st_hs0++; if (st_fh0 < 0) st_fh0 = e_h; end
      if (hs === 1'b1) begin st_hs1++; if (st_fh1 < 0) st_fh1 = e_h; end
      if (vs === 1'b0) st_vs0++;
      if (vs === 1'b1) st_vs1++;
   endtask

   initial begin
      cfg_valid = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clear_stats();

      // Reset state
      #2 rst = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_all();
      chk("rst_hs_idle", hs, 1);
      chk("rst_ready", cfg_ready, 1);

      // Release: first edge arms, second edge shows pixel 0,0
      rst = 1'b1;
      tick();
      chk("e1_pix_v", pix_v, 0);
      clear_stats();
      tick();
      chk("e2_pix_v", pix_v, 1);
      chk("e2_frame_start", frame_start, 1);
      chk("e2_line_start", line_start, 1);
      chk("e2_pix_xy", {pix_x, pix_y}, 0);

      // Rest of frame 0 under reset timing (23 x 10)
      repeat (228) tick();
      chk("f0_fid_before_wrap", frame_id, 0);
      tick();
      chk("f0_fid_after_wrap", frame_id, 1);
      chk("f0_pix_v_count", st_pv, 96);
      chk("f0_hs_low_count", st_hs0, 30);
      chk("f0_hs_low_first_h", st_fh0, 18);
      chk("f0_vs_low_count", st_vs0, 46);

      // Rejected offers: zero sync, horizontal total 1024, zero vertical act
      set_cfg(16, 2, 0, 2, 6, 1, 2, 1, 0, 0);
      cfg_valid = 1'b1;
      tick();
      chk("rej_sw0_err", cfg_err, 1);
      chk("rej_sw0_ready", cfg_ready, 1);
      cfg_valid = 1'b0;
      tick();
      chk("rej_sw0_err_gone", cfg_err, 0);
      set_cfg(1000, 20, 3, 1, 6, 1, 2, 1, 0, 0);
      cfg_valid = 1'b1;
      tick();
      chk("rej_htot_err", cfg_err, 1);
      cfg_valid = 1'b0;
      tick();
      set_cfg(16, 2, 3, 2, 0, 1, 2, 1, 0, 0);
      cfg_valid = 1'b1;
      tick();
      chk("rej_vact_err", cfg_err, 1);
      cfg_valid = 1'b0;
      tick();
      chk("rej_ready", cfg_ready, 1);

      // Accept 8/2/2/2 x 4/1/1/1 pol 1 mid-frame, then hold a second offer
      set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1, 1);
      cfg_valid = 1'b1;
      tick();
      chk("acc1_ready_low", cfg_ready, 0);
      set_cfg(6, 1, 1, 1, 3, 1, 1, 1, 0, 0);
      for (int i = 0; i < 300 && cfg_ready !== 1'b1; i++) tick();
      chk("acc1_ready_back", cfg_ready, 1);
      chk("acc1_fid_wrap", frame_id, 2);

      // First frame under 14 x 7 timing; held second offer accepted now
      clear_stats();
      tick();
      chk("acc2_ready_low", cfg_ready, 0);
      chk("new_frame_start", frame_start, 1);
      cfg_valid = 1'b0;
      repeat (97) tick();
      chk("f14_pix_v_count", st_pv, 32);
      chk("f14_hs_high_count", st_hs1, 14);
      chk("f14_hs_high_first_h", st_fh1, 10);
      chk("f14_vs_high_count", st_vs1, 14);
      chk("f14_fid_wrap0", frame_id, 0);
      chk("acc2_applied_ready", cfg_ready, 1);

      // Frame under second config: 9 x 6
      clear_stats();
      repeat (54) tick();
      chk("f9_pix_v_count", st_pv, 18);
      chk("f9_hs_low_count", st_hs0, 6);
      chk("f9_fid", frame_id, 1);

      // Reset mid-line with a config pending
      set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1, 1);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("pend_before_rst", cfg_ready, 0);
      repeat (5) tick();
      rst = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("midrst_ready", cfg_ready, 1);
      chk("midrst_pix_v", pix_v, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      tick();
      clear_stats();
      repeat (230) tick();
      chk("post_rst_pix_v_count", st_pv, 96);
      chk("post_rst_fid", frame_id, 1);
      chk("post_rst_ready", cfg_ready, 1);
      clear_stats();
      repeat (23) tick();
      chk("post_rst_line_hs_low", st_hs0, 3);
      chk("post_rst_line_pix_v", st_pv, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- pA, 10, counter and coordinate width in bits
- fA, 32, frame counter width in bits
- FRAMES, 275625, frame_id wrap modulus
- H_ACT / H_FP / H_SW / H_BP, 640 / 16 / 96 / 48, reset horizontal timing
- V_ACT / V_FP / V_SW / V_BP, 480 / 10 / 2 / 33, reset vertical timing
- HS_POL / VS_POL, 0 / 0, reset sync polarity (1 = active-high)

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-low
- cfg_h_act, cfg_h_fp, cfg_h_sw, cfg_h_bp  in  pA each  new horizontal timing
- cfg_v_act, cfg_v_fp, cfg_v_sw, cfg_v_bp  in  pA each  new vertical timing
- cfg_hs_pol, cfg_vs_pol  in  1 each  new sync polarities
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config slot free
- cfg_err  out  1  one-cycle pulse: offered config rejected
- pix_x, pix_y  out  pA each  active-area coordinate
- pix_v  out  1  pixel in active area
- hs, vs  out  1 each  sync outputs, polarity applied
- line_start, frame_start  out  1 each  one-cycle markers
- frame_id  out  fA  frame counter

Function
REQ-003 Internal counters h_cnt and v_cnt (pA bits) SHALL order each line/frame as active, front porch, sync, back porch; h_tot = act+fp+sw+bp of the live timing set.
REQ-004 h_cnt SHALL increment every cycle and wrap from h_tot-1 to 0; v_cnt SHALL increment on that wrap and wrap from v_tot-1 to 0.
REQ-005 frame_id SHALL increment when both counters wrap together, and wrap from FRAMES-1 to 0.
REQ-006 All outputs SHALL be registered with exactly 1-cycle latency from counter state.
REQ-007 pix_v SHALL be 1 iff h_cnt < act_h and v_cnt < act_v.
REQ-008 pix_x / pix_y SHALL equal h_cnt / v_cnt when pix_v=1, else 0.
REQ-009 Horizontal sync SHALL be asserted iff act_h+fp_h <= h_cnt < act_h+fp_h+sw_h (vertical analogous); hs = asserted XNOR hs_pol, i.e. the idle level is !pol.
REQ-010 line_start SHALL pulse for h_cnt==0; frame_start SHALL pulse for h_cnt==0 and v_cnt==0.
REQ-011 Config handshake SHALL be accepted on a cycle with cfg_valid=1 and cfg_ready=1; accepted fields go to a pending shadow, and cfg_ready drops to 0.
REQ-012 A config SHALL be rejected when act=0, sw=0, or h_tot/v_tot exceeds 2^pA-1 (either axis); rejection pulses cfg_err 1 cycle later, nothing is stored, and cfg_ready stays 1.
REQ-013 A pending config SHALL become live on the cycle both counters wrap, so the next cycle has counters 0,0 under the new timing; cfg_ready returns to 1 on that same cycle.
REQ-014 A cfg_valid offer while cfg_ready=0 SHALL be ignored; the bench holds cfg_valid until accepted.
REQ-015 A config offer on the frame-wrap cycle with an empty slot SHALL be stored as pending and applied at the following frame wrap.
REQ-016 Timing SHALL never change mid-frame.
REQ-017 Counter arithmetic SHALL be unsigned pA-bit; intermediate sums SHALL be computed at pA+2 bits for the REQ-012 range check.

Reset
REQ-018 While rst=0, the following SHALL hold:
- h_cnt = v_cnt = 0; frame_id = 0
- pix_x = pix_y = 0; pix_v = 0
- line_start = frame_start = 0; cfg_err = 0; cfg_ready = 1
- hs = !HS_POL, vs = !VS_POL
- live timing = parameters; pending cleared
REQ-019 Reset asserted mid-frame or with a config pending SHALL discard the pending config and restart from counters 0,0 after release.
REQ-020 The first clock edge after release SHALL start counting; at the second edge, pix_v=1, frame_start=1, line_start=1, pix_x=pix_y=0.

Verification
REQ-021 Default parameters, release reset, run 800x525 cycles -> exactly 307200 pix_v cycles; hs low for cycles h_cnt 656..751; vs low for lines 490..491; frame_id=1 after one frame.
REQ-022 Offer cfg 8/2/2/2 x 4/1/1/1, pol=1, mid-frame -> accepted, cfg_ready=0 until frame wrap; next frame h_tot=14, v_tot=7, hs high for h_cnt 10..11.
REQ-023 Offer cfg with cfg_h_sw=0 -> cfg_err single pulse, cfg_ready stays 1, timing unchanged.
REQ-024 Second offer while one is pending -> ignored; first applied at wrap; second accepted only once cfg_ready=1.
REQ-025 FRAMES=3 with small timing -> frame_id sequence 0,1,2,0.
REQ-026 Assert rst mid-line with config pending -> all outputs at reset values immediately; after release, default timing and no apply at the next wrap.
